// File: rtl/lvds_link_test_ctrl.sv
// LVDS link qualification sequencer: clear, settle, dwell, check; one retry with inverted polarity.
// Latency: DONE at CLR_CYC+SETTLE_CYC+dwell+3 cycles after START when the first attempt passes (plus TRAIN_CYC per attempt under LVDS_LINK_TEST_TRAIN_EN).
// No backpressure: START is ignored while BUSY, ABORT returns to IDLE on the next cycle.
module lvds_link_test_ctrl #(
    parameter int unsigned CLR_CYC    = 4,
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned DWELL_CYC  = 1048576,
    parameter int unsigned MIN_RECV   = 1024,
    parameter int unsigned TIMER_W    = 24
`ifdef LVDS_LINK_TEST_TRAIN_EN
    ,
    parameter int unsigned TRAIN_CYC  = 256
`endif
) (
    input  logic        CLK,
    input  logic        RSTX,
    input  logic        START,
    input  logic        ABORT,
    input  logic [63:0] ERR_CNT,
    input  logic [57:0] RECV_CNT,
    output logic        CLR,
    output logic        INV,
    output logic [1:0]  PATTERN,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [31:0] ERR_SNAP
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SETTLE = 3'd2,
        S_DWELL  = 3'd3,
        S_CHECK  = 3'd4,
        S_FIN    = 3'd5
`ifdef LVDS_LINK_TEST_TRAIN_EN
        ,
        S_TRAIN  = 3'd6
`endif
    } state_t;

    localparam logic [TIMER_W-1:0] L_CLR_LAST    = TIMER_W'(CLR_CYC - 1);
    localparam logic [TIMER_W-1:0] L_SETTLE_LAST = TIMER_W'(SETTLE_CYC - 1);
    localparam logic [TIMER_W-1:0] L_DWELL_LAST  = TIMER_W'(DWELL_CYC - 1);
    localparam logic [57:0]        L_MIN_RECV    = 58'(MIN_RECV);
`ifdef LVDS_LINK_TEST_TRAIN_EN
    localparam logic [TIMER_W-1:0] L_TRAIN_LAST  = TIMER_W'(TRAIN_CYC - 1);
    localparam state_t             L_FIRST       = S_TRAIN;
`else
    localparam state_t             L_FIRST       = S_CLEAR;
`endif

    state_t               r_state;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_clr;
    logic                 r_inv;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [31:0]          r_err_snap;

    state_t               w_state_nxt;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic                 w_inv_nxt;
    logic                 w_pass_nxt;
    logic                 w_done_nxt;
    logic [31:0]          w_snap_nxt;
    logic                 w_recv_ok;
    logic                 w_link_ok;
    logic [31:0]          w_snap_val;

    assign w_recv_ok  = (RECV_CNT >= L_MIN_RECV);
    assign w_link_ok  = (ERR_CNT == 64'd0) && w_recv_ok;
    assign w_snap_val = (ERR_CNT[63:32] != 32'd0) ? 32'hFFFF_FFFF : ERR_CNT[31:0];

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + TIMER_W'(1);
        w_inv_nxt   = r_inv;
        w_pass_nxt  = r_pass;
        w_done_nxt  = 1'b0;
        w_snap_nxt  = r_err_snap;
        if (ABORT && (r_state != S_IDLE)) begin
            // Abort keeps INV and ERR_SNAP so software can see how far the test got.
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
            w_pass_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_timer_nxt = '0;
                    if (START && !ABORT) begin
                        w_state_nxt = L_FIRST;
                        w_inv_nxt   = 1'b0;
                        w_pass_nxt  = 1'b0;
                        w_snap_nxt  = '0;
                    end
                end
`ifdef LVDS_LINK_TEST_TRAIN_EN
                S_TRAIN: begin
                    if (r_timer == L_TRAIN_LAST) begin
                        w_state_nxt = S_CLEAR;
                        w_timer_nxt = '0;
                    end
                end
`endif
                S_CLEAR: begin
                    if (r_timer == L_CLR_LAST) begin
                        w_state_nxt = S_SETTLE;
                        w_timer_nxt = '0;
                    end
                end
                S_SETTLE: begin
                    if (r_timer == L_SETTLE_LAST) begin
                        w_state_nxt = S_DWELL;
                        w_timer_nxt = '0;
                    end
                end
                S_DWELL: begin
                    if (w_recv_ok || (r_timer == L_DWELL_LAST)) begin
                        w_state_nxt = S_CHECK;
                        w_timer_nxt = '0;
                    end
                end
                S_CHECK: begin
                    w_timer_nxt = '0;
                    w_snap_nxt  = w_snap_val;
                    if (w_link_ok) begin
                        w_pass_nxt  = 1'b1;
                        w_state_nxt = S_FIN;
                    end else if (!r_inv) begin
                        w_inv_nxt   = 1'b1;
                        w_state_nxt = L_FIRST;
                    end else begin
                        w_pass_nxt  = 1'b0;
                        w_state_nxt = S_FIN;
                    end
                end
                S_FIN: begin
                    w_timer_nxt = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Controls are registered from the next state so CLR/BUSY never glitch.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_clr      <= 1'b0;
            r_inv      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_snap <= '0;
        end else begin
            r_clr      <= (w_state_nxt == S_CLEAR);
            r_inv      <= w_inv_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_err_snap <= w_snap_nxt;
        end
    end

`ifdef LVDS_LINK_TEST_TRAIN_EN
    logic [1:0] r_pattern;

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_pattern <= 2'd0;
        end else begin
            r_pattern <= (w_state_nxt == S_TRAIN) ? 2'd1 : 2'd0;
        end
    end

    assign PATTERN = r_pattern;
`else
    assign PATTERN = 2'd0;
`endif

    assign CLR      = r_clr;
    assign INV      = r_inv;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign PASS     = r_pass;
    assign ERR_SNAP = r_err_snap;

endmodule

// File: tb/tb_lvds_link_test_ctrl.sv
// Scoreboard bench for lvds_link_test_ctrl: stimulus queues expected results, a monitor checks each DONE.
`timescale 1ns/1ps
module tb_lvds_link_test_ctrl;
    localparam int C_CLR = 4;
`ifdef LVDS_LINK_TEST_TRAIN_EN
    localparam int TR = 16;
`else
    localparam int TR = 0;
`endif

    logic        CLK = 1'b0;
    logic        RSTX = 1'b0;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic [63:0] ERR_CNT = '0;
    logic [57:0] RECV_CNT = '0;
    logic        CLR, INV, BUSY, DONE, PASS;
    logic [1:0]  PATTERN;
    logic [31:0] ERR_SNAP;

    lvds_link_test_ctrl #(
        .CLR_CYC(4), .SETTLE_CYC(8), .DWELL_CYC(100), .MIN_RECV(20), .TIMER_W(24)
`ifdef LVDS_LINK_TEST_TRAIN_EN
        , .TRAIN_CYC(16)
`endif
    ) dut (
        .CLK(CLK), .RSTX(RSTX), .START(START), .ABORT(ABORT),
        .ERR_CNT(ERR_CNT), .RECV_CNT(RECV_CNT),
        .CLR(CLR), .INV(INV), .PATTERN(PATTERN), .BUSY(BUSY),
        .DONE(DONE), .PASS(PASS), .ERR_SNAP(ERR_SNAP)
    );

    typedef struct {
        bit          pass;
        bit          inv;
        logic [31:0] snap;
        int          lat;
        int          attempts;
        int          t_start;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          m_ramp = 1'b1;
    logic [63:0] m_e0 = '0;
    logic [63:0] m_e1 = '0;
    int          clr_acc = 0;
    int          pat_acc = 0;
    int          ovl_acc = 0;
    logic        prev_done = 1'b0;

    initial forever #5 CLK = ~CLK;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Link datapath stand-in: CLR zeroes both counters; otherwise RECV ramps (or sticks at 3)
    // and ERR reflects the error level chosen for the current polarity.
    initial forever begin
        @(negedge CLK);
        if (CLR) begin
            RECV_CNT = '0;
            ERR_CNT  = '0;
        end else begin
            RECV_CNT = m_ramp ? RECV_CNT + 58'd1 : 58'd3;
            ERR_CNT  = INV ? m_e1 : m_e0;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                chk("done_single_cycle", 64'(prev_done), 64'd0);
                chk("done_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pass", 64'(PASS), 64'(e.pass));
                    chk("inv", 64'(INV), 64'(e.inv));
                    chk("err_snap", 64'(ERR_SNAP), 64'(e.snap));
                    chk("latency", 64'(cyc - e.t_start), 64'(e.lat));
                    chk("clr_cycles", 64'(clr_acc), 64'(C_CLR * e.attempts));
                    chk("train_cycles", 64'(pat_acc), 64'(TR * e.attempts));
                    chk("pattern_overlap", 64'(ovl_acc), 64'd0);
                    chk("busy_at_done", 64'(BUSY), 64'd0);
                end
            end
            prev_done = DONE;
            if (BUSY) begin
                clr_acc += int'(CLR);
                pat_acc += int'(PATTERN == 2'd1);
                ovl_acc += int'((PATTERN != 2'd0 && CLR) || PATTERN > 2'd1);
            end else begin
                clr_acc = 0;
                pat_acc = 0;
                ovl_acc = 0;
            end
        end
    end

    task automatic start_test(input bit ramp, input logic [63:0] e0, input logic [63:0] e1,
                              input bit push, input bit xp, input bit xi, input logic [31:0] xs,
                              input int lat, input int attempts);
        exp_t e;
        @(negedge CLK);
        m_ramp = ramp;
        m_e0   = e0;
        m_e1   = e1;
        START  = 1'b1;
        e.pass = xp; e.inv = xi; e.snap = xs; e.lat = lat; e.attempts = attempts;
        e.t_start = cyc;
        if (push) sb.push_back(e);
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d after %0d cycles, required 0", sb.size(), budget);
            sb.delete();
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("reset_outputs", 64'({CLR, INV, PATTERN, BUSY, DONE, PASS, ERR_SNAP}), 64'd0);
        RSTX = 1'b1;
        repeat (2) @(negedge CLK);

        // Ramp reaches 20 after 12 dwell cycles: 4+8+12+3 = 27; a retry costs 25 more.
        start_test(1'b1, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0, 32'd0, 27 + TR, 1);
        drain(600);
        start_test(1'b1, 64'd5, 64'd0, 1'b1, 1'b1, 1'b1, 32'd0, 52 + 2*TR, 2);
        drain(600);
        start_test(1'b1, 64'd5, 64'd5, 1'b1, 1'b0, 1'b1, 32'd5, 52 + 2*TR, 2);
        drain(600);
        // Stuck RECV: full 100-cycle dwell, two attempts of 4+8+100+1, plus 2.
        start_test(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b1, 32'd0, 228 + 2*TR, 2);
        drain(600);
        start_test(1'b1, 64'h2_0000_0000, 64'h2_0000_0000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 52 + 2*TR, 2);
        drain(600);

        // Abort in the second attempt's dwell (cycle 40 after START).
        start_test(1'b1, 64'd5, 64'd5, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0);
        repeat (39 + 2*TR) @(negedge CLK);
        chk("busy_before_abort", 64'(BUSY), 64'd1);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("abort_busy", 64'(BUSY), 64'd0);
        chk("abort_clr", 64'(CLR), 64'd0);
        chk("abort_done", 64'(DONE), 64'd0);
        chk("abort_pass", 64'(PASS), 64'd0);
        chk("abort_inv_kept", 64'(INV), 64'd1);
        chk("abort_snap_kept", 64'(ERR_SNAP), 64'd5);
        repeat (120) @(negedge CLK);

        START = 1'b1;
        ABORT = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        ABORT = 1'b0;
        chk("start_abort_busy", 64'(BUSY), 64'd0);
        repeat (5) @(negedge CLK);
        chk("start_abort_busy_later", 64'(BUSY), 64'd0);
        chk("start_abort_inv", 64'(INV), 64'd1);

        // Second START at cycle 10 must not restart the sequence.
        start_test(1'b1, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0, 32'd0, 27 + TR, 1);
        repeat (9) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        drain(600);

        // Asynchronous reset during the second CLR burst.
        start_test(1'b1, 64'd5, 64'd5, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0);
        repeat (26 + 2*TR) @(negedge CLK);
        chk("mid_test_clr_inv_busy", 64'({CLR, INV, BUSY}), 64'h7);
        #2;
        RSTX = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({CLR, INV, PATTERN, BUSY, DONE, PASS, ERR_SNAP}), 64'd0);
        @(negedge CLK);
        RSTX = 1'b1;
        repeat (100) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
